cis_pipe16: RTL and testbench
=============================

CIS_PIPE16 -- requirements
Module: cis_pipe16

Interface
REQ-001 The block SHALL take parameter SIZE, default 16, as the operand width in bits; SIZE SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set on a, b and bin is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered operand set this cycle.
REQ-006 The block SHALL have ports a and b, input, SIZE bits each: the minuend and subtrahend, unsigned.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: diff, bout and ovf hold a valid result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream side takes the result.
REQ-010 The block SHALL have port diff, output, SIZE bits: the difference.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow flag (see REQ-030).

Function
REQ-013 The block SHALL compute diff = (a - b - bin) mod 2^SIZE, with bout = 1 exactly when a < b + bin as unsigned values.
REQ-014 Arithmetic SHALL be carried out as a + ~b + ~bin on carry-increment 4-bit slices: each slice computes a zero-carry-in 4-bit sum, then a 4-bit half-adder increment chain on the incoming carry, and its carry-out is the OR of both carries; bout = ~(final carry).
REQ-015 The pipeline SHALL have N = SIZE/4 stages; stage k SHALL resolve slice k (bits 4k+3:4k) and register it with the unresolved upper operand bits, the partial diff and the carry.
REQ-016 The advance condition SHALL be: advance = ~out_valid | out_ready. The block SHALL drive in_ready = advance combinationally.
REQ-017 An operand set SHALL be accepted on a cycle where in_valid & in_ready is 1.
REQ-018 When advance is 1, every stage SHALL shift forward, and the stage-0 valid bit SHALL load in_valid.
REQ-019 When advance is 0, all stages SHALL hold their contents.
REQ-020 Latency SHALL be exactly N cycles: a set accepted at edge t SHALL appear with out_valid = 1 after edge t+N-1 when there is no stall.
REQ-021 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-022 While out_valid = 1 and out_ready = 0, diff, bout and ovf SHALL remain stable.
REQ-023 Bubbles, i.e. cycles with in_valid = 0, SHALL propagate as invalid stages and SHALL NOT produce out_valid.
REQ-024 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-025 While out_valid = 0, the values of diff, bout and ovf are don't-care, but the implementation SHALL keep them at the last-stage register value.
REQ-026 Wrap-around: a = 0, b = 1, bin = 0 SHALL give diff = all ones and bout = 1.

Reset
REQ-027 When rst_n is low, the block SHALL asynchronously clear all stage valid bits and data registers, giving out_valid = 0, diff = 0, bout = 0 and ovf = 0.
REQ-028 When rst_n is low, in_ready SHALL be 1, because out_valid = 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results; the first accept after rst_n rises SHALL behave as from an empty pipeline.

Configuration
REQ-030 With macro CIS_SIGNED_OVF_EN defined, ovf SHALL be 1 when a - b - bin, read as two's-complement SIZE-bit values, overflows (a[SIZE-1] != b[SIZE-1] and diff[SIZE-1] != a[SIZE-1]), and ovf SHALL be pipelined alongside diff.
REQ-031 Without CIS_SIGNED_OVF_EN, the ovf port SHALL still exist and SHALL be driven constant 0, with no extra registers.

Verification
REQ-032 For SIZE=16, accept a=16'h1234, b=16'h0235, bin=0 -> after 4 cycles out_valid=1, diff=16'h0FFF, bout=0.
REQ-033 For SIZE=16, accept a=0, b=1, bin=0, then a=16'h8000, b=1, bin=1 on consecutive cycles -> results: diff=16'hFFFF with bout=1, then diff=16'h7FFE with bout=0 (ovf=1 when the macro is defined); each one cycle apart.
REQ-034 For SIZE=16, stream 10 random sets with out_ready=0 from cycle 6 to cycle 9 -> in_ready=0 during the stall, outputs stable, all 10 results correct and in order.
REQ-035 For SIZE=16, pulse rst_n low while 3 results are in flight -> out_valid=0 immediately, no stale results after release, next accepted set correct with latency 4.
REQ-036 For SIZE=16, alternate in_valid 1/0 with a=b=16'hFFFF, bin=1 -> out_valid alternates, diff=16'hFFFF, bout=1.
REQ-037 For SIZE=4, accept a=4'h3, b=4'h5, bin=0 -> result after 1 cycle: diff=4'hE, bout=1; ovf=0 in both macro builds.

Source files
------------

// File: rtl/cis_pipe16.sv
// cis_pipe16: SIZE-bit subtractor diff = a - b - bin, pipelined one 4-bit carry-increment slice per stage.
// Build option: define CIS_SIGNED_OVF_EN to get a registered signed-overflow flag on ovf; otherwise ovf is tied low.
module cis_pipe16 #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bout,
    output logic            ovf
);
    localparam int N = SIZE / 4;

    logic            v_q  [N];
    logic [SIZE-1:0] a_q  [N];
    logic [SIZE-1:0] nb_q [N];
    logic [SIZE-1:0] d_q  [N];
    logic            bw_q [N];

    logic            v_x  [N];
    logic [SIZE-1:0] a_x  [N];
    logic [SIZE-1:0] nb_x [N];
    logic [SIZE-1:0] d_x  [N];
    logic            c_x  [N];
    logic [SIZE-1:0] d_d  [N];
    logic            bw_d [N];

    logic [3:0] s0, s1;
    logic       c0, hc;
    logic       adv;

    assign out_valid = v_q[N-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign diff      = d_q[N-1];
    assign bout      = bw_q[N-1];

    // Stage inputs and slice arithmetic: stage k adds slice k of a + ~b plus the carry left by stage k-1.
    // Each stage stores a borrow (inverted carry) so that cleared registers read as bout = 0.
    always_comb begin
        v_x[0]  = in_valid;
        a_x[0]  = a;
        nb_x[0] = ~b;
        d_x[0]  = '0;
        c_x[0]  = ~bin;
        for (int k = 1; k < N; k++) begin
            v_x[k]  = v_q[k-1];
            a_x[k]  = a_q[k-1];
            nb_x[k] = nb_q[k-1];
            d_x[k]  = d_q[k-1];
            c_x[k]  = ~bw_q[k-1];
        end
        s0 = '0;
        s1 = '0;
        c0 = 1'b0;
        hc = 1'b0;
        for (int k = 0; k < N; k++) begin
            {c0, s0} = {1'b0, a_x[k][4*k +: 4]} + {1'b0, nb_x[k][4*k +: 4]};
            hc = c_x[k];
            for (int i = 0; i < 4; i++) begin
                s1[i] = s0[i] ^ hc;
                hc    = s0[i] & hc;
            end
            d_d[k]          = d_x[k];
            d_d[k][4*k +: 4] = s1;
            bw_d[k]         = ~(c0 | hc);
        end
    end

    // Pipeline registers: everything shifts together on advance and holds on a downstream stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                nb_q[k] <= '0;
                d_q[k]  <= '0;
                bw_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                v_q[k]  <= v_x[k];
                a_q[k]  <= a_x[k];
                nb_q[k] <= nb_x[k];
                d_q[k]  <= d_d[k];
                bw_q[k] <= bw_d[k];
            end
        end
    end

`ifdef CIS_SIGNED_OVF_EN
    logic ovf_d, ovf_q;

    assign ovf_d = (a_x[N-1][SIZE-1] ^ ~nb_x[N-1][SIZE-1]) & (d_d[N-1][SIZE-1] ^ a_x[N-1][SIZE-1]);
    assign ovf   = ovf_q;

    // Overflow flag is resolved in the last stage and loads alongside the final diff slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (adv)
            ovf_q <= ovf_d;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cis_pipe16.sv
// tb_cis_pipe16: directed bench for cis_pipe16 (SIZE=16 and SIZE=4 instances) with an in-order result scoreboard.
module tb_cis_pipe16;
`ifdef CIS_SIGNED_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
    logic [15:0] a, b, diff;
    logic        in_valid4, in_ready4, bin4, out_valid4, bout4, ovf4;
    logic [3:0]  a4, b4, diff4;

    int n_chk = 0;
    int n_pass = 0;
    int n_pop = 0;
    logic mon_en = 1'b0;
    logic [17:0] q[$];

    cis_pipe16 #(.SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    cis_pipe16 #(.SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(1'b1),
        .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic [16:0] f;
        f = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        return {OVF_EN & (x[15] ^ y[15]) & (f[15] ^ x[15]), f[16], f[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic bi);
        in_valid = v;
        a = x;
        b = y;
        bin = bi;
        cyc();
    endtask

    // Scoreboard: record every accepted set, compare every transferred result in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_result", 32'd1, 32'd0);
                else begin
                    logic [17:0] e;
                    e = q.pop_front();
                    n_pop++;
                    chk("sb_result", {14'd0, ovf, bout, diff}, {14'd0, e});
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    logic [15:0] va [10] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234,
                             16'hABCD, 16'h0001, 16'h5555, 16'hF00F, 16'h0F0F};
    logic [15:0] vb [10] = '{16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h4321,
                             16'h1234, 16'h0001, 16'hAAAA, 16'h0FF0, 16'hF0F0};
    logic        vc [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int idx, pops0;
        logic acc;
        logic [17:0] held;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        cyc();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outs", {ovf, bout, diff}, 18'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid4", out_valid4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        mon_en = 1'b1;

        // Basic latency: result visible after the fourth edge.
        drive(1'b1, 16'h1234, 16'h0235, 1'b0);
        chk("lat_e1", out_valid, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("lat_e2", out_valid, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("lat_e3", out_valid, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("lat_e4_valid", out_valid, 1'b1);
        chk("lat_e4_result", {ovf, bout, diff}, {1'b0, 1'b0, 16'h0FFF});
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("lat_drained", out_valid, 1'b0);

        // Back-to-back: wrap-around then signed overflow case.
        drive(1'b1, 16'h0000, 16'h0001, 1'b0);
        drive(1'b1, 16'h8000, 16'h0001, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("b2b_first_valid", out_valid, 1'b1);
        chk("b2b_wrap", {ovf, bout, diff}, {1'b0, 1'b1, 16'hFFFF});
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("b2b_second_valid", out_valid, 1'b1);
        chk("b2b_ovf", {ovf, bout, diff}, {OVF_EN, 1'b0, 16'h7FFE});
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("b2b_drained", out_valid, 1'b0);

        // Stream of 10 sets with a downstream stall on cycles 6..9.
        idx = 0;
        pops0 = n_pop;
        held = '0;
        for (int c = 0; c < 60 && (idx < 10 || q.size() != 0); c++) begin
            out_ready = !(c >= 6 && c <= 9);
            in_valid = idx < 10;
            if (idx < 10) begin
                a = va[idx];
                b = vb[idx];
                bin = vc[idx];
            end
            @(negedge clk);
            if (c >= 6 && c <= 9) begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_out_valid", out_valid, 1'b1);
                if (c == 6) held = {ovf, bout, diff};
                else chk("stall_stable", {ovf, bout, diff}, held);
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) idx++;
        end
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("stream_accepted", idx, 10);
        chk("stream_results", n_pop - pops0, 10);
        chk("stream_queue_empty", q.size(), 0);

        // Alternating bubbles.
        for (int c = 0; c < 12; c++) begin
            drive((c < 8) && (c % 2 == 0), 16'hFFFF, 16'hFFFF, 1'b1);
            chk("alt_valid", out_valid, (c >= 3) && ((c - 3) % 2 == 0) && (c - 3 < 8));
            if (out_valid) chk("alt_result", {ovf, bout, diff}, {1'b0, 1'b1, 16'hFFFF});
        end
        chk("alt_queue_empty", q.size(), 0);

        // Reset with three results in flight.
        mon_en = 1'b0;
        drive(1'b1, 16'h0005, 16'h0003, 1'b0);
        drive(1'b1, 16'h0006, 16'h0003, 1'b0);
        drive(1'b1, 16'h0007, 16'h0003, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_outs", {ovf, bout, diff}, 18'd0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0);
            chk("post_rst_no_stale", out_valid, 1'b0);
        end
        drive(1'b1, 16'h9000, 16'h1000, 1'b1);
        chk("post_rst_e1", out_valid, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("post_rst_e2", out_valid, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("post_rst_e3", out_valid, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("post_rst_e4_valid", out_valid, 1'b1);
        chk("post_rst_result", {ovf, bout, diff}, {OVF_EN, 1'b0, 16'h7FFF});
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        chk("post_rst_drained", out_valid, 1'b0);

        // Single-stage build: one-cycle latency.
        in_valid4 = 1'b1;
        a4 = 4'h3;
        b4 = 4'h5;
        bin4 = 1'b0;
        cyc();
        in_valid4 = 1'b0;
        chk("s4_valid", out_valid4, 1'b1);
        chk("s4_result", {ovf4, bout4, diff4}, {1'b0, 1'b1, 4'hE});
        cyc();
        chk("s4_drained", out_valid4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
